// File: rtl/shift_out_ctrl_if.sv
// Handshake and serial-output bundle for shift_out_ctrl.
// The master drives the requests and the slave (the controller) returns the serial lines and status.
interface shift_out_ctrl_if #(
    parameter int DATA_W = 16
) ();
    logic              start;
    logic [DATA_W-1:0] data;
    logic              lsb_first;
    logic              abort;
    logic              sclk;
    logic              sdata;
    logic              latch;
    logic              busy;
    logic              done;

    modport master (
        output start, data, lsb_first, abort,
        input  sclk, sdata, latch, busy, done
    );

    modport slave (
        input  start, data, lsb_first, abort,
        output sclk, sdata, latch, busy, done
    );
endinterface

// File: rtl/shift_out_ctrl.sv
// Serial shift-out controller: clocks a captured word into an external shift register,
// strobes its storage latch, then pulses done. Every output comes straight from a flop.
module shift_out_ctrl #(
    parameter int DATA_W  = 16,
    parameter int CLK_DIV = 4
) (
    input logic           clk,
    input logic           reset_n,
    shift_out_ctrl_if.slave bus
);
    localparam int PH_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_LATCH = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // The word is stored in transmit order so the outgoing bit is always bit 0.
    function automatic logic [DATA_W-1:0] tx_order(input logic [DATA_W-1:0] w, input logic lsb);
        logic [DATA_W-1:0] r;
        for (int i = 0; i < DATA_W; i++) begin
            r[i] = lsb ? w[i] : w[DATA_W-1-i];
        end
        return r;
    endfunction

    logic [1:0]        state_r, state_s;
    logic              phase_hi_r, phase_hi_s;
    logic [PH_W-1:0]   phase_cnt_r, phase_cnt_s;
    logic [BIT_W-1:0]  bit_cnt_r, bit_cnt_s;
    logic [DATA_W-1:0] word_r, word_s;
    logic              sclk_r, sclk_s;
    logic              sdata_r, sdata_s;
    logic              latch_r, latch_s;
    logic              busy_r, busy_s;
    logic              done_r, done_s;
    logic [DATA_W-1:0] cap_word_s;
    logic [DATA_W-1:0] shifted_s;

    assign cap_word_s = tx_order(bus.data, bus.lsb_first);
    assign shifted_s  = word_r >> 1'b1;

    // Next-state and next-output logic for the transfer sequencer.
    always_comb begin
        state_s     = state_r;
        phase_hi_s  = phase_hi_r;
        phase_cnt_s = phase_cnt_r;
        bit_cnt_s   = bit_cnt_r;
        word_s      = word_r;
        sclk_s      = sclk_r;
        sdata_s     = sdata_r;
        latch_s     = latch_r;
        busy_s      = busy_r;
        done_s      = done_r;
        if (bus.abort && (state_r != ST_IDLE)) begin
            state_s     = ST_IDLE;
            phase_hi_s  = 1'b0;
            phase_cnt_s = {PH_W{1'b0}};
            bit_cnt_s   = {BIT_W{1'b0}};
            word_s      = {DATA_W{1'b0}};
            sclk_s      = 1'b0;
            sdata_s     = 1'b0;
            latch_s     = 1'b0;
            busy_s      = 1'b0;
            done_s      = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    // abort in IDLE suppresses a simultaneous start
                    if (bus.start && !bus.abort) begin
                        state_s     = ST_SHIFT;
                        phase_hi_s  = 1'b0;
                        phase_cnt_s = {PH_W{1'b0}};
                        bit_cnt_s   = {BIT_W{1'b0}};
                        word_s      = cap_word_s;
                        sclk_s      = 1'b0;
                        sdata_s     = cap_word_s[0];
                        latch_s     = 1'b0;
                        busy_s      = 1'b1;
                        done_s      = 1'b0;
                    end else begin
                        sclk_s  = 1'b0;
                        sdata_s = 1'b0;
                        latch_s = 1'b0;
                        busy_s  = 1'b0;
                        done_s  = 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (phase_cnt_r != PH_LAST) begin
                        phase_cnt_s = phase_cnt_r + PH_W'(1'b1);
                    end else begin
                        phase_cnt_s = {PH_W{1'b0}};
                        if (!phase_hi_r) begin
                            phase_hi_s = 1'b1;
                            sclk_s     = 1'b1;
                        end else if (bit_cnt_r != BIT_LAST) begin
                            // sdata only moves here, as sclk falls
                            phase_hi_s = 1'b0;
                            sclk_s     = 1'b0;
                            bit_cnt_s  = bit_cnt_r + BIT_W'(1'b1);
                            word_s     = shifted_s;
                            sdata_s    = shifted_s[0];
                        end else begin
                            state_s    = ST_LATCH;
                            phase_hi_s = 1'b0;
                            sclk_s     = 1'b0;
                            sdata_s    = 1'b0;
                            latch_s    = 1'b1;
                            word_s     = {DATA_W{1'b0}};
                        end
                    end
                end
                ST_LATCH: begin
                    if (phase_cnt_r != PH_LAST) begin
                        phase_cnt_s = phase_cnt_r + PH_W'(1'b1);
                    end else begin
                        phase_cnt_s = {PH_W{1'b0}};
                        state_s     = ST_DONE;
                        latch_s     = 1'b0;
                        done_s      = 1'b1;
                    end
                end
                ST_DONE: begin
                    state_s   = ST_IDLE;
                    bit_cnt_s = {BIT_W{1'b0}};
                    busy_s    = 1'b0;
                    done_s    = 1'b0;
                end
                default: begin
                    state_s     = ST_IDLE;
                    phase_hi_s  = 1'b0;
                    phase_cnt_s = {PH_W{1'b0}};
                    bit_cnt_s   = {BIT_W{1'b0}};
                    word_s      = {DATA_W{1'b0}};
                    sclk_s      = 1'b0;
                    sdata_s     = 1'b0;
                    latch_s     = 1'b0;
                    busy_s      = 1'b0;
                    done_s      = 1'b0;
                end
            endcase
        end
    end

    // State, counter, captured-word and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            phase_hi_r  <= 1'b0;
            phase_cnt_r <= {PH_W{1'b0}};
            bit_cnt_r   <= {BIT_W{1'b0}};
            word_r      <= {DATA_W{1'b0}};
            sclk_r      <= 1'b0;
            sdata_r     <= 1'b0;
            latch_r     <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            phase_hi_r  <= phase_hi_s;
            phase_cnt_r <= phase_cnt_s;
            bit_cnt_r   <= bit_cnt_s;
            word_r      <= word_s;
            sclk_r      <= sclk_s;
            sdata_r     <= sdata_s;
            latch_r     <= latch_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
        end
    end

    assign bus.sclk  = sclk_r;
    assign bus.sdata = sdata_r;
    assign bus.latch = latch_r;
    assign bus.busy  = busy_r;
    assign bus.done  = done_r;
endmodule

// File: tb/tb_shift_out_ctrl.sv
// Bench for shift_out_ctrl: two configurations (16/4 and 8/1) checked every cycle against a
// timeline model driven by elapsed cycles since acceptance, plus literal sequence/timing checks.
module tb_shift_out_ctrl;
    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    shift_out_ctrl_if #(.DATA_W(16)) bus_a ();
    shift_out_ctrl_if #(.DATA_W(8))  bus_b ();

    shift_out_ctrl #(.DATA_W(16), .CLK_DIV(4)) dut_a (.clk(clk), .reset_n(reset_n), .bus(bus_a));
    shift_out_ctrl #(.DATA_W(8),  .CLK_DIV(1)) dut_b (.clk(clk), .reset_n(reset_n), .bus(bus_b));

    localparam int FIN_A = (2*16+1)*4;
    localparam int FIN_B = (2*8+1)*1;

    int tests = 0;
    int fails = 0;

    // Model state: whether a transfer is live, cycles since acceptance, captured word and order.
    int          cyc = 0;
    bit          act_a = 1'b0, act_b = 1'b0;
    int          t_a = 0, t_b = 0;
    logic [31:0] w_a = 32'd0, w_b = 32'd0;
    bit          l_a = 1'b0, l_b = 1'b0;
    int          acc_a[$];

    // Reference model advance on each clock edge; reset empties it immediately.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            act_a <= 1'b0;
            act_b <= 1'b0;
        end else begin
            cyc <= cyc + 1;
            if (act_a) begin
                if (bus_a.abort || t_a >= FIN_A) act_a <= 1'b0;
                t_a <= t_a + 1;
            end else if (bus_a.start && !bus_a.abort) begin
                act_a <= 1'b1; t_a <= 0; w_a <= 32'(bus_a.data); l_a <= bus_a.lsb_first;
                acc_a.push_back(cyc + 1);
            end
            if (act_b) begin
                if (bus_b.abort || t_b >= FIN_B) act_b <= 1'b0;
                t_b <= t_b + 1;
            end else if (bus_b.start && !bus_b.abort) begin
                act_b <= 1'b1; t_b <= 0; w_b <= 32'(bus_b.data); l_b <= bus_b.lsb_first;
            end
        end
    end

    // Expected {sclk, sdata, latch, busy, done} t cycles after acceptance.
    function automatic logic [4:0] expect_out(bit act, int t, int dw, int cd, logic [31:0] w, bit lsb);
        int   i;
        logic b, hi;
        if (!act) return 5'b00000;
        if (t < 2*dw*cd) begin
            i  = t / (2*cd);
            b  = lsb ? w[i] : w[dw-1-i];
            hi = ((t % (2*cd)) >= cd);
            return {hi, b, 1'b0, 1'b1, 1'b0};
        end
        if (t < (2*dw+1)*cd) return 5'b00110;
        return 5'b00011;
    endfunction

    bit   prev_sclk_a = 1'b0;
    logic rise_a[$];
    int   done_a[$];
    int   latch_cnt_a = 0;
    int   done_cnt_b = 0;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
        end
    endtask

    // One clock: sample on the falling edge, compare both DUTs with the model, log events.
    task automatic tick();
        logic [4:0] ga, ea, gb, eb;
        @(negedge clk);
        ga = {bus_a.sclk, bus_a.sdata, bus_a.latch, bus_a.busy, bus_a.done};
        gb = {bus_b.sclk, bus_b.sdata, bus_b.latch, bus_b.busy, bus_b.done};
        ea = reset_n ? expect_out(act_a, t_a, 16, 4, w_a, l_a) : 5'b00000;
        eb = reset_n ? expect_out(act_b, t_b, 8, 1, w_b, l_b) : 5'b00000;
        tests++;
        if (ga !== ea) begin
            fails++;
            $display("FAIL cycle_a cyc=%0d got=%b expected=%b (sclk,sdata,latch,busy,done)", cyc, ga, ea);
        end
        tests++;
        if (gb !== eb) begin
            fails++;
            $display("FAIL cycle_b cyc=%0d got=%b expected=%b (sclk,sdata,latch,busy,done)", cyc, gb, eb);
        end
        if (bus_a.sclk && !prev_sclk_a) rise_a.push_back(bus_a.sdata);
        prev_sclk_a = bus_a.sclk;
        if (bus_a.done)  done_a.push_back(cyc);
        if (bus_a.latch) latch_cnt_a++;
        if (bus_b.done)  done_cnt_b++;
    endtask

    function automatic logic [15:0] rises_from(int base);
        logic [15:0] s = 16'h0000;
        for (int k = 0; k < 16; k++) begin
            s = {s[14:0], (base + k < rise_a.size()) ? rise_a[base+k] : 1'b0};
        end
        return s;
    endfunction

    task automatic pulse_start_a(input logic [15:0] d, input logic lsb);
        bus_a.data = d; bus_a.lsb_first = lsb; bus_a.start = 1'b1;
        tick();
        bus_a.start = 1'b0;
    endtask

    initial begin
        int rb, db, ab, lb, db_b;
        reset_n = 1'b0;
        bus_a.start = 1'b0; bus_a.abort = 1'b0; bus_a.data = 16'h0000; bus_a.lsb_first = 1'b0;
        bus_b.start = 1'b0; bus_b.abort = 1'b0; bus_b.data = 8'h00;    bus_b.lsb_first = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        check("reset_outputs_a", 32'({bus_a.sclk, bus_a.sdata, bus_a.latch, bus_a.busy, bus_a.done}), 32'd0);

        // MSB-first reference word
        rb = rise_a.size(); db = done_a.size();
        pulse_start_a(16'hA5C3, 1'b0);
        repeat (140) tick();
        check("rise_count_msb", 32'(rise_a.size() - rb), 32'd16);
        check("seq_msb", 32'(rises_from(rb)), 32'h0000A5C3);
        check("done_latency_msb", (done_a.size() > db && acc_a.size() > 0) ? 32'(done_a[db] - acc_a[acc_a.size()-1]) : 32'hFFFFFFFF, 32'd132);

        // LSB-first, data scrambled after capture
        rb = rise_a.size(); lb = latch_cnt_a;
        pulse_start_a(16'hA5C3, 1'b1);
        repeat (4) tick();
        bus_a.data = 16'h0000;
        repeat (136) tick();
        check("seq_lsb", 32'(rises_from(rb)), 32'h0000C3A5);
        check("latch_cycles_lsb", 32'(latch_cnt_a - lb), 32'd4);

        // abort at E0+37, fresh start at E0+40
        ab = acc_a.size(); db = done_a.size(); lb = latch_cnt_a;
        pulse_start_a(16'h1234, 1'b0);
        repeat (36) tick();
        bus_a.abort = 1'b1;
        tick();
        bus_a.abort = 1'b0;
        check("abort_busy_clear", 32'({bus_a.busy, bus_a.sclk}), 32'd0);
        repeat (2) tick();
        pulse_start_a(16'h8001, 1'b0);
        repeat (140) tick();
        check("abort_restart_gap", (acc_a.size() >= ab + 2) ? 32'(acc_a[ab+1] - acc_a[ab]) : 32'hFFFFFFFF, 32'd40);
        check("abort_done_count", 32'(done_a.size() - db), 32'd1);
        check("abort_latch_cycles", 32'(latch_cnt_a - lb), 32'd4);

        // asynchronous reset in the middle of a bit
        pulse_start_a(16'hFFFF, 1'b0);
        repeat (20) tick();
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1 check("async_reset_outputs", 32'({bus_a.sclk, bus_a.sdata, bus_a.latch, bus_a.busy, bus_a.done}), 32'd0);
        repeat (3) tick();
        reset_n = 1'b1;
        db = done_a.size(); lb = latch_cnt_a;
        repeat (150) tick();
        check("post_reset_no_done", 32'(done_a.size() - db), 32'd0);
        check("post_reset_no_latch", 32'(latch_cnt_a - lb), 32'd0);

        // CLK_DIV=1 back-to-back with start held
        db_b = done_cnt_b;
        bus_b.data = 8'h5A; bus_b.lsb_first = 1'b0; bus_b.start = 1'b1;
        repeat (95) tick();
        bus_b.start = 1'b0;
        repeat (30) tick();
        check("b2b_done_count", 32'(done_cnt_b - db_b), 32'd5);

        // randomized traffic on both instances
        for (int n = 0; n < 2000; n++) begin
            bus_a.start     = ($urandom_range(0, 7) == 0);
            bus_a.abort     = ($urandom_range(0, 99) == 0);
            bus_a.data      = 16'($urandom);
            bus_a.lsb_first = 1'($urandom);
            bus_b.start     = ($urandom_range(0, 3) == 0);
            bus_b.abort     = ($urandom_range(0, 39) == 0);
            bus_b.data      = 8'($urandom);
            bus_b.lsb_first = 1'($urandom);
            tick();
        end
        bus_a.start = 1'b0; bus_a.abort = 1'b0;
        bus_b.start = 1'b0; bus_b.abort = 1'b0;
        repeat (300) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
